// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
//   NOP                  : instruction returned for misaligned / out-of-range fetches
//   DEFAULT_DEPTH_WORDS  : default number of 32-bit instruction words
//   DEFAULT_FIFO_DEPTH   : default number of buffered responses
//   rsp_entry_t          : one buffered response {data, err}
//   word_in_range()      : true when a byte address selects an existing word
package imem_responder_pkg;

  localparam logic [31:0] NOP                 = 32'h0000_0013;
  localparam int          DEFAULT_DEPTH_WORDS = 64;
  localparam int          DEFAULT_FIFO_DEPTH  = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_entry_t;

  localparam int RSP_W = $bits(rsp_entry_t);

  // Word index is addr[31:2]; compare at 32 bits so large addresses never alias.
  function automatic logic word_in_range(input logic [31:0] addr, input int depth_words);
    return {2'b00, addr[31:2]} < 32'(depth_words);
  endfunction

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// resp_fifo: small circular response buffer with synchronous flush.
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   flush            : empties the buffer at the edge; blocks push and pop that cycle
//   push, push_data  : write an entry (taken when not full, or when popping the same edge)
//   pop              : consumer takes the head (ignored when empty)
//   valid, full      : buffer holds at least one / DEPTH entries
//   head_data        : oldest entry, stable until popped
module resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign valid     = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && valid && !flush;
    // A full buffer still accepts when the head leaves at the same edge.
    do_push  = push && !flush && (!full || do_pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking is reserved for always_comb.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the storage array is reset too, so the head reads zero while reset is held.
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: register-file instruction memory answering fetches through a
// response FIFO, with a side port for program loading.
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   req_valid/addr/ready  : fetch request handshake (byte address, word aligned)
//   rsp_valid/data/err    : head of the response FIFO; err flags misaligned/out-of-range
//   rsp_ready             : consumer takes the head
//   flush                 : drop all buffered responses (redirect)
//   ld_we/addr/data       : program-load write; bad addresses are ignored
//   fetch_cnt             : saturating count of consumed responses
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  input  logic        flush,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [15:0] fetch_cnt
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] mem_d [DEPTH_WORDS];
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  logic [IDX_W-1:0] req_idx, ld_idx;
  logic             ld_ok;
  logic             fifo_full;
  logic             push, pop_fire;
  rsp_entry_t       req_entry, head_entry;

  assign req_idx = req_addr[IDX_W+1:2];
  assign ld_idx  = ld_addr[IDX_W+1:2];
  assign ld_ok   = ld_we && (ld_addr[1:0] == 2'b00) && word_in_range(ld_addr, DEPTH_WORDS);

  assign req_ready = !reset && !flush && (!fifo_full || rsp_ready);
  assign push      = req_valid && req_ready;
  assign pop_fire  = rsp_valid && rsp_ready && !flush;

  // Fetch reads the registered array, so a same-edge load is seen only by later fetches.
  always_comb begin
    req_entry = '{data: NOP, err: 1'b1};
    if ((req_addr[1:0] == 2'b00) && word_in_range(req_addr, DEPTH_WORDS)) begin
      req_entry = '{data: mem_q[req_idx], err: 1'b0};
    end
  end

  always_comb begin
    mem_d       = mem_q;
    fetch_cnt_d = fetch_cnt_q;
    if (ld_ok) begin
      mem_d[ld_idx] = ld_data;
    end
    if (pop_fire && (fetch_cnt_q != 16'hFFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q       <= '{default: '0};
      fetch_cnt_q <= '0;
    end else begin
      mem_q       <= mem_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RSP_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (req_entry),
    .pop       (rsp_ready),
    .valid     (rsp_valid),
    .full      (fifo_full),
    .head_data (head_entry)
  );

  assign rsp_data  = head_entry.data;
  assign rsp_err   = head_entry.err;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
  import imem_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic        flush;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [15:0] fetch_cnt;

  int checks = 0;
  int errors = 0;
  rsp_entry_t sb [$];

  imem_responder #(.DEPTH_WORDS(64), .FIFO_DEPTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .flush     (flush),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head against the scoreboard every cycle it is valid,
  // and retires the entry when the handshake will complete at the next edge.
  always @(negedge clock) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        check("rsp_data", rsp_data, sb[0].data);
        check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        if (rsp_ready && !flush) void'(sb.pop_front());
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clock); #1;
    ld_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic e);
    int waited = 0;
    req_valid = 1'b1; req_addr = a;
    @(negedge clock);
    while (!req_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) check("req_accept_timeout", 32'(req_ready), 32'd1);
    else sb.push_back('{data: d, err: e});
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("rsp_latency1", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    flush = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    #2;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_fetch_cnt", 32'(fetch_cnt), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0; req_valid = 1'b0;
    @(posedge clock); #1;
    check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);

    // Program load, including two writes that must be dropped.
    load(32'h0000_0000, 32'h1111_1111);
    load(32'h0000_0004, 32'h2222_2222);
    load(32'h0000_0008, 32'h5555_5555);
    load(32'h0000_00FC, 32'hCAFE_F00D);
    load(32'h0000_000A, 32'hDEAD_BEEF);
    load(32'h0000_0100, 32'h1234_5678);

    // Streaming fetch with the consumer always ready.
    rsp_ready = 1'b1;
    issue(32'h0, 32'h1111_1111, 1'b0);
    issue(32'h4, 32'h2222_2222, 1'b0);
    drain();
    check("stream_fetch_cnt", 32'(fetch_cnt), 32'd2);

    // Read-before-write: load and fetch of word 8 on the same edge.
    ld_we = 1'b1; ld_addr = 32'h8; ld_data = 32'hAAAA_AAAA;
    issue(32'h8, 32'h5555_5555, 1'b0);
    ld_we = 1'b0;
    issue(32'h8, 32'hAAAA_AAAA, 1'b0);
    drain();
    check("rbw_fetch_cnt", 32'(fetch_cnt), 32'd4);

    // Error responses and the last in-range word.
    issue(32'h2,   NOP, 1'b1);
    issue(32'h100, NOP, 1'b1);
    issue(32'hFC,  32'hCAFE_F00D, 1'b0);
    drain();
    check("err_fetch_cnt", 32'(fetch_cnt), 32'd7);

    // Backpressure: two buffered, third waits and enters on the first pop.
    rsp_ready = 1'b0;
    issue(32'h0, 32'h1111_1111, 1'b0);
    issue(32'h4, 32'h2222_2222, 1'b0);
    req_valid = 1'b1; req_addr = 32'h8;
    repeat (2) begin
      @(negedge clock);
      check("full_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("accept_with_pop_ready", 32'(req_ready), 32'd1);
    check("accept_with_pop_valid", 32'(rsp_valid), 32'd1);
    sb.push_back('{data: 32'hAAAA_AAAA, err: 1'b0});
    @(posedge clock); #1;
    req_valid = 1'b0;
    drain();
    check("bp_fetch_cnt", 32'(fetch_cnt), 32'd10);

    // Flush with two buffered and a request pending.
    rsp_ready = 1'b0;
    issue(32'h0, 32'h1111_1111, 1'b0);
    issue(32'h4, 32'h2222_2222, 1'b0);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    @(negedge clock);
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock);
    sb.delete();
    #1;
    flush = 1'b0; req_valid = 1'b0;
    check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    check("flush_fetch_cnt", 32'(fetch_cnt), 32'd10);
    @(negedge clock);
    check("flush_rsp_valid_later", 32'(rsp_valid), 32'd0);

    // Asynchronous reset with the buffer full.
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    issue(32'h4, 32'h2222_2222, 1'b0);
    issue(32'h8, 32'hAAAA_AAAA, 1'b0);
    #2;
    req_valid = 1'b1; req_addr = 32'h0;
    reset = 1'b1;
    sb.delete();
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    check("async_rst_rsp_data", rsp_data, 32'h0);
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0;
    @(posedge clock); #1;
    check("after_rst_no_rsp", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    issue(32'h0, 32'h0000_0000, 1'b0);
    drain();
    check("after_rst_fetch_cnt", 32'(fetch_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
